// File: rtl/pipe_transfer_chain.sv
// Parametrised stage-to-stage transfer chain: PC, instruction and sideband move through
// DEPTH register stages under a global stall, with per-stage valid, flush, occupancy and kill count.
module pipe_transfer_chain #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 2,
  parameter logic [31:0] NOP    = 32'h0000_0013,
  parameter int unsigned KCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [DEPTH-1:0]  flush,
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_inst,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst,
  output logic [DATA_W-1:0] out_data,
  output logic [DEPTH-1:0]  stage_valid,
  output logic [3:0]        inflight,
  output logic [KCNT_W-1:0] killed
);

  logic [DEPTH-1:0]  v_q, v_adv, v_nxt;
  logic [31:0]       pc_q   [DEPTH];
  logic [31:0]       pc_adv [DEPTH];
  logic [31:0]       pc_nxt [DEPTH];
  logic [31:0]       inst_q   [DEPTH];
  logic [31:0]       inst_adv [DEPTH];
  logic [31:0]       inst_nxt [DEPTH];
  logic [DATA_W-1:0] data_q   [DEPTH];
  logic [DATA_W-1:0] data_adv [DEPTH];
  logic [DATA_W-1:0] data_nxt [DEPTH];

  logic [3:0]        kill_cnt, occ_cnt, occ_q;
  logic [KCNT_W+3:0] ksum;
  logic [KCNT_W-1:0] killed_q, killed_nxt;

  // Advance candidates: stage 0 takes the (bubble-masked) input, stage i takes stage i-1.
  always_comb begin
    v_adv       = '0;
    v_adv[0]    = in_valid;
    pc_adv[0]   = in_valid ? in_pc   : '0;
    inst_adv[0] = in_valid ? in_inst : NOP;
    data_adv[0] = in_valid ? in_data : '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      v_adv[i]    = v_q[i-1];
      pc_adv[i]   = pc_q[i-1];
      inst_adv[i] = inst_q[i-1];
      data_adv[i] = data_q[i-1];
    end
  end

  // Flush overrides the advance/hold choice, so it also kills in place during stall.
  always_comb begin
    kill_cnt = '0;
    occ_cnt  = '0;
    v_nxt    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      v_nxt[i]    = stall ? v_q[i]    : v_adv[i];
      pc_nxt[i]   = stall ? pc_q[i]   : pc_adv[i];
      inst_nxt[i] = stall ? inst_q[i] : inst_adv[i];
      data_nxt[i] = stall ? data_q[i] : data_adv[i];
      if (flush[i]) begin
        if (v_nxt[i]) kill_cnt = kill_cnt + 4'd1;
        v_nxt[i]    = 1'b0;
        pc_nxt[i]   = '0;
        inst_nxt[i] = NOP;
        data_nxt[i] = '0;
      end
      occ_cnt = occ_cnt + {3'b000, v_nxt[i]};
    end
  end

  always_comb begin
    ksum = {4'b0000, killed_q} + {{KCNT_W{1'b0}}, kill_cnt};
    if (ksum[KCNT_W+3:KCNT_W] != 4'b0000) killed_nxt = '1;
    else                                 killed_nxt = ksum[KCNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q      <= '0;
      occ_q    <= '0;
      killed_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= NOP;
        data_q[i] <= '0;
      end
    end else begin
      v_q      <= v_nxt;
      occ_q    <= occ_cnt;
      killed_q <= killed_nxt;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= pc_nxt[i];
        inst_q[i] <= inst_nxt[i];
        data_q[i] <= data_nxt[i];
      end
    end
  end

  assign out_valid   = v_q[DEPTH-1];
  assign out_pc      = pc_q[DEPTH-1];
  assign out_inst    = inst_q[DEPTH-1];
  assign out_data    = data_q[DEPTH-1];
  assign stage_valid = v_q;
  assign inflight    = occ_q;
  assign killed      = killed_q;

endmodule

// File: tb/tb_pipe_transfer_chain.sv
// Directed bench for pipe_transfer_chain: main DEPTH=2 instance plus a KCNT_W=4 instance
// for the saturating kill counter.
module tb_pipe_transfer_chain;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, in_valid;
  logic [1:0]  flush;
  logic [31:0] in_pc, in_inst;
  logic [63:0] in_data;
  logic        out_valid;
  logic [31:0] out_pc, out_inst;
  logic [63:0] out_data;
  logic [1:0]  stage_valid;
  logic [3:0]  inflight;
  logic [15:0] killed;

  logic        s_reset, s_stall, s_in_valid;
  logic [1:0]  s_flush;
  logic [31:0] s_in_pc, s_in_inst;
  logic [63:0] s_in_data;
  logic        s_out_valid;
  logic [31:0] s_out_pc, s_out_inst;
  logic [63:0] s_out_data;
  logic [1:0]  s_stage_valid;
  logic [3:0]  s_inflight;
  logic [3:0]  s_killed;

  pipe_transfer_chain #(.DATA_W(64), .DEPTH(2), .NOP(NOP_W), .KCNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_data(in_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_data(out_data),
    .stage_valid(stage_valid), .inflight(inflight), .killed(killed)
  );

  pipe_transfer_chain #(.DATA_W(64), .DEPTH(2), .NOP(NOP_W), .KCNT_W(4)) u_sat (
    .clk(clk), .reset(s_reset), .stall(s_stall), .flush(s_flush),
    .in_valid(s_in_valid), .in_pc(s_in_pc), .in_inst(s_in_inst), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_pc(s_out_pc), .out_inst(s_out_inst), .out_data(s_out_data),
    .stage_valid(s_stage_valid), .inflight(s_inflight), .killed(s_killed)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic [63:0] data);
    in_valid = v;
    in_pc    = pc;
    in_inst  = inst;
    in_data  = data;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 2'b00;
    feed(1'b0, '0, '0, '0);
    s_reset = 1'b0; s_stall = 1'b0; s_flush = 2'b00; s_in_valid = 1'b0;
    s_in_pc = '0; s_in_inst = '0; s_in_data = '0;

    // Reset state
    tick(); tick();
    check("rst_inst", out_inst, NOP_W);
    check("rst_pc", out_pc, 0);
    check("rst_inflight", inflight, 0);
    check("rst_killed", killed, 0);
    check("rst_valid", stage_valid, 2'b00);

    // Streaming, latency 2
    reset = 1'b1;
    feed(1'b1, 32'h100, 32'h00500093, 64'hA5A5_0000_0000_0100);
    tick();
    check("s1_inflight", inflight, 1);
    check("s1_out_valid", out_valid, 0);
    feed(1'b1, 32'h104, 32'h00108113, 64'h0104);
    tick();
    check("s2_out_pc", out_pc, 32'h100);
    check("s2_out_inst", out_inst, 32'h00500093);
    check("s2_out_data", out_data, 64'hA5A5_0000_0000_0100);
    check("s2_inflight", inflight, 2);
    feed(1'b1, 32'h108, 32'h002081b3, 64'h0108);
    tick();
    check("s3_out_pc", out_pc, 32'h104);
    check("s3_inflight", inflight, 2);
    feed(1'b0, '0, '0, '0);
    tick();
    check("s4_out_pc", out_pc, 32'h108);
    check("s4_out_inst", out_inst, 32'h002081b3);
    check("s4_inflight", inflight, 1);

    // Stall hold
    feed(1'b1, 32'h1FC, 32'h0, 64'h0);
    tick();
    feed(1'b1, 32'h200, 32'h0, 64'h0);
    tick();
    stall = 1'b1;
    for (int unsigned c = 0; c < 3; c++) begin
      feed(1'b1, 32'h700 + 32'(c * 4), 32'h1, 64'h1);
      tick();
      check("stall_out_pc", out_pc, 32'h1FC);
      check("stall_inflight", inflight, 2);
    end
    stall = 1'b0;
    feed(1'b0, '0, '0, '0);
    tick();
    check("unstall_out_pc", out_pc, 32'h200);

    // Branch flush of both stages with a valid incoming entry
    feed(1'b1, 32'h300, 32'h00500093, 64'h3);
    tick();
    feed(1'b1, 32'h304, 32'h00500093, 64'h3);
    tick();
    check("pre_flush_valid", stage_valid, 2'b11);
    feed(1'b1, 32'h308, 32'h00500093, 64'h3);
    flush = 2'b11;
    tick();
    flush = 2'b00;
    check("bflush_valid", stage_valid, 2'b00);
    check("bflush_inst", out_inst, NOP_W);
    check("bflush_pc", out_pc, 0);
    check("bflush_inflight", inflight, 0);
    check("bflush_killed", killed, 2);

    // Flush during stall kills stage 1 in place
    feed(1'b1, 32'h400, 32'h00108113, 64'h4);
    tick();
    feed(1'b1, 32'h404, 32'h00108113, 64'h4);
    tick();
    stall = 1'b1;
    flush = 2'b10;
    feed(1'b1, 32'h800, 32'h1, 64'h1);
    tick();
    check("sflush_valid", stage_valid, 2'b01);
    check("sflush_out_inst", out_inst, NOP_W);
    check("sflush_killed", killed, 3);
    check("sflush_inflight", inflight, 1);
    // Flushing the now-empty stage 1 again counts nothing
    tick();
    check("empty_flush_killed", killed, 3);
    flush = 2'b00;
    stall = 1'b0;
    feed(1'b0, '0, '0, '0);
    tick();
    check("sflush_s0_kept", out_pc, 32'h404);
    check("sflush_s0_valid", out_valid, 1);

    // Invalid input becomes a bubble
    feed(1'b0, 32'h500, 32'hDEADBEEF, 64'h55);
    tick();
    tick();
    check("inv_inst", out_inst, NOP_W);
    check("inv_pc", out_pc, 0);
    check("inv_data", out_data, 0);
    check("inv_valid", out_valid, 0);

    // Reset mid-run beats stall and flush, clears killed
    feed(1'b1, 32'h600, 32'h00500093, 64'h6);
    tick();
    feed(1'b1, 32'h604, 32'h00500093, 64'h6);
    tick();
    check("pre_rst_inflight", inflight, 2);
    reset = 1'b0; stall = 1'b1; flush = 2'b11;
    tick();
    check("mrst_valid", stage_valid, 2'b00);
    check("mrst_inflight", inflight, 0);
    check("mrst_killed", killed, 0);
    check("mrst_inst", out_inst, NOP_W);
    reset = 1'b1; stall = 1'b0; flush = 2'b00;

    // Saturating killed counter (KCNT_W=4)
    s_reset = 1'b1; s_in_valid = 1'b1; s_flush = 2'b01;
    s_in_pc = 32'h900; s_in_inst = 32'h00500093;
    for (int unsigned c = 1; c <= 20; c++) begin
      tick();
      check("sat_killed", 64'(s_killed), (c > 15) ? 64'd15 : 64'(c));
    end
    check("sat_inflight", s_inflight, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_transfer_chain.md
Name: pipe_transfer_chain

Overview:
- Parametrised successor to the fixed stage-to-stage transfer registers in the Riscv151 pipeline.
- Carries PC, instruction and a DATA_W sideband through DEPTH register stages under one global stall.
- Adds what the fixed transfers lack:
  - per-stage valid tracking;
  - per-stage flush that inserts a NOP bubble;
  - an in-flight occupancy count;
  - a saturating counter of killed instructions for CSR/perf visibility.

Parameters:
DATA_W, 64, width of the sideband payload (e.g. rs1d/rs2d, alu_out/rs2d)
DEPTH, 2, number of register stages; legal range 1..8
NOP, 32'h0000_0013, instruction word written into bubbles (addi x0,x0,0)
KCNT_W, 16, width of the killed-instruction counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset; reset==0 at a rising edge clears all state
stall  input  1  freeze request from the memory system; 1 = hold all stages
flush  input  DEPTH  flush[i]=1: the entry that stage i holds after this edge becomes a bubble
in_valid  input  1  input entry is a real instruction
in_pc  input  32  PC of the input entry
in_inst  input  32  instruction of the input entry
in_data  input  DATA_W  sideband of the input entry
out_valid  output  1  valid bit of stage DEPTH-1
out_pc  output  32  PC of stage DEPTH-1
out_inst  output  32  instruction of stage DEPTH-1
out_data  output  DATA_W  sideband of stage DEPTH-1
stage_valid  output  DEPTH  valid bit of every stage; bit i = stage i
inflight  output  4  number of valid stages, 0..DEPTH
killed  output  KCNT_W  number of valid entries destroyed by flush since reset; saturating

Behaviour:
- All outputs are registered. There is no combinational path from any input to any output.
- Reset (reset==0 at a rising edge) has priority over stall and flush. Every stage resets to:
  - valid=0, pc=0, inst=NOP, data=0;
  - inflight=0, killed=0.
- A bubble is the same value as the reset state: valid=0, pc=0, inst=NOP, data=0.
- stall=0 (advance):
  - Stage 0 loads {in_valid,in_pc,in_inst,in_data}. If in_valid=0, the input is still loaded, but inst is forced to NOP and pc/data to 0, so the stage becomes a bubble.
  - Stage i>0 loads stage i-1.
  - The old stage DEPTH-1 content leaves the chain without being counted as killed.
- stall=1 (hold): every stage keeps its content. Input is ignored.
- flush is applied after the advance/hold selection.
  - For each i with flush[i]=1, the selected next value of stage i is replaced by a bubble.
  - Flush therefore acts during stall too, killing in place.
- killed accounting, evaluated per edge:
  - k = number of i where flush[i]=1 and the selected next value for stage i had valid=1.
  - killed <= min(killed+k, 2^KCNT_W-1); the counter never wraps.
- inflight <= popcount of the post-flush next-state valid bits. It always equals popcount(stage_valid) in the same cycle.
- Latency is DEPTH cycles from input to out_*, with no stall and no flush. Each stall cycle adds one cycle.
- Simultaneous events:
  - stall=1 with flush[i]=1 kills stage i in place.
  - flush[0]=1 with stall=0 and in_valid=1 discards the incoming entry and counts 1 toward killed.
  - Flushing an already-empty stage counts 0.
- Reset mid-operation empties the chain the same cycle. The killed counter is cleared, not incremented.
- DEPTH=1 is legal: stage 0 is also the output stage.

Test Plan:
- Reset then streaming:
  - Stimulus: hold reset=0 for 2 cycles, then reset=1, DEPTH=2, stall=0. Feed in_valid=1 with pc=0x100/0x104/0x108 and inst=0x00500093/0x00108113/0x002081b3 on consecutive cycles.
  - Required: during reset, out_inst=0x00000013, inflight=0, killed=0. pc=0x100 appears at out_pc exactly 2 cycles after entry, and the three PCs leave in order. inflight goes 1,2,2.
- Stall hold:
  - Stimulus: chain full with pc 0x200 (stage 0) and 0x1FC (stage 1). Assert stall=1 for 3 cycles while changing in_pc.
  - Required: stage contents unchanged for all 3 cycles; out_pc=0x1FC throughout. After stall drops, out_pc=0x200 on the next edge.
- Branch flush:
  - Stimulus: stages hold valid pc 0x300 and 0x304; apply flush=2'b11 for 1 cycle with in_valid=1, pc=0x308.
  - Required: stage 0 and stage 1 become bubbles (inst=0x00000013, valid=0); inflight=0; killed increments by 2.
- Flush during stall:
  - Stimulus: stall=1 with flush=2'b10, stage 1 valid pc 0x400.
  - Required: stage 1 becomes a bubble in place, stage 0 is unchanged, killed +1, inflight drops by 1.
- Counter saturation:
  - Stimulus: KCNT_W=4, valid input each cycle with flush[0]=1 for 20 cycles.
  - Required: killed counts 1..15 and then stays at 15.
- Invalid input and reset mid-run:
  - Stimulus: in_valid=0 with in_inst=0xDEADBEEF. Then reset=0 while stall=1 and flush=all ones.
  - Required: the stage holds inst=0x00000013, pc=0, data=0. After the reset edge all stages are bubbles, inflight=0, killed=0.
